// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start bit, LSB-first data, optional even parity, stop bit(s).
// Optional parity bit compiled in with `define UART_TX_PARITY_EN.
//
// state    | meaning
// S_IDLE   | line high, ready for a byte
// S_START  | start bit (low)
// S_DATA   | data bits, LSB first
// S_PARITY | even parity bit (UART_TX_PARITY_EN only)
// S_STOP   | STOP_BITS stop bits (high)
module uart_tx_ctrl #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 bit_tick
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = 4;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_tx;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_tick;

    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic                   w_tx_nxt;
    logic                   w_last;

`ifdef UART_TX_PARITY_EN
    logic                   r_par;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par <= 1'b0;
        end else if (r_state == S_IDLE && tx_valid) begin
            r_par <= ^tx_data;
        end
    end
`endif

    assign w_last = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        if (r_state != S_IDLE) begin
            w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
        end
        case (r_state)
            S_IDLE: begin
                if (tx_valid) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = tx_data;
                end
            end
            S_START: begin
                if (w_last) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_last) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_idx == DATA_LAST) begin
                        w_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_last) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_last) begin
                    if (r_idx == STOP_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase

        // Outputs are registered from the next state so tx moves on the same edge as the FSM.
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_nxt = r_par;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_tick  <= (w_state_nxt != S_IDLE) && (w_cnt_nxt == CNT_LAST);
        end
    end

    assign tx       = r_tx;
    assign tx_ready = r_ready;
    assign tx_busy  = r_busy;
    assign bit_tick = r_tick;

endmodule
